ofmap_out_ctrl: RTL and testbench

//   Output-side counterpart of the weight input path. Accepts one vector of up to 5 accumulator

---
 rtl/ofmap_out_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_ofmap_out_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ofmap_out_ctrl.sv
// Output-feature-map controller: requantizes accumulator lanes to int8, packs them into words and queues them in a FWFT FIFO.
// Optional build macro OUT_RELU_EN clamps requantized bytes to [0,127].
module ofmap_out_ctrl #(
    parameter int OUTPUT_WIDTH = 32,
    parameter int ACC_WIDTH    = 32,
    parameter int FIFO_DEPTH   = 16,
    parameter int NUM_LANES    = 5
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic                    CLEAR_FIFO,
    input  logic                    FLUSH,
    input  logic [4:0]              PARAM_SHIFT,
    input  logic [2:0]              PARAM_LANES,
    input  logic                    RES_VALID,
    output logic                    RES_READY,
    input  logic [ACC_WIDTH-1:0]    RES_DATA_0,
    input  logic [ACC_WIDTH-1:0]    RES_DATA_1,
    input  logic [ACC_WIDTH-1:0]    RES_DATA_2,
    input  logic [ACC_WIDTH-1:0]    RES_DATA_3,
    input  logic [ACC_WIDTH-1:0]    RES_DATA_4,
    input  logic                    FIFO_RD_CMD,
    output logic [OUTPUT_WIDTH-1:0] FIFO_RD_DATA,
    output logic                    FIFO_EMPTY,
    output logic                    FIFO_FULL,
    output logic                    PACK_BUSY,
    output logic [15:0]             WORD_COUNT
);

    localparam int BYTES = OUTPUT_WIDTH / 8;
    localparam int BW    = $clog2(BYTES);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    localparam logic [BW-1:0]          LAST_BYTE = BW'(BYTES - 1);
    localparam logic [PW-1:0]          LAST_PTR  = PW'(FIFO_DEPTH - 1);
    localparam logic signed [ACC_WIDTH:0] Q_MAX  = (ACC_WIDTH+1)'(127);
    localparam logic signed [ACC_WIDTH:0] Q_MIN  = -(ACC_WIDTH+1)'(128);

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_SERIALIZE = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic                    r_clear_d;
    logic                    r_flush_d;
    logic                    r_flush_pending;
    logic [BW-1:0]           r_byte_cnt;
    logic [OUTPUT_WIDTH-1:0] r_pack;
    logic [2:0]              r_lane_idx;
    logic [2:0]              r_eff_lanes;
    logic [4:0]              r_shift;
    logic [15:0]             r_word_count;
    logic [ACC_WIDTH-1:0]    r_lane [5];

    logic [OUTPUT_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]           r_wptr;
    logic [PW-1:0]           r_rptr;
    logic [CW-1:0]           r_count;

    logic                    w_clear;
    logic                    w_flush_edge;
    logic                    w_accept;
    logic                    w_ser_step;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_flush_clr;
    logic                    w_empty;
    logic                    w_full;
    logic [2:0]              w_eff_lanes;
    logic [OUTPUT_WIDTH-1:0] w_pack_new;
    logic [OUTPUT_WIDTH-1:0] w_push_data;
    logic [ACC_WIDTH-1:0]    w_lane_sel;
    logic signed [ACC_WIDTH:0] w_x;
    logic signed [ACC_WIDTH:0] w_rnd;
    logic signed [ACC_WIDTH:0] w_v;
    logic [7:0]              w_q;

    assign w_clear      = CLEAR_FIFO & ~r_clear_d;
    assign w_flush_edge = FLUSH & ~r_flush_d;
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CW'(FIFO_DEPTH));
    assign w_pop        = FIFO_RD_CMD & ~w_empty;

    assign RES_READY    = RESETN & (r_state == ST_IDLE) & ~w_clear & ~r_flush_pending;
    assign w_accept     = RES_VALID & RES_READY;

    assign w_eff_lanes  = (PARAM_LANES == 3'd0)              ? 3'd1 :
                          (PARAM_LANES > 3'(NUM_LANES))      ? 3'(NUM_LANES) : PARAM_LANES;

    assign FIFO_EMPTY   = w_empty;
    assign FIFO_FULL    = w_full;
    assign FIFO_RD_DATA = w_empty ? '0 : r_mem[r_rptr];
    assign PACK_BUSY    = (r_state != ST_IDLE) | (r_byte_cnt != '0) | r_flush_pending;
    assign WORD_COUNT   = r_word_count;

    // Round-half-up arithmetic shift in one guard bit wider than the accumulator, then saturate.
    always_comb begin
        w_lane_sel = r_lane[r_lane_idx];
        w_x        = {w_lane_sel[ACC_WIDTH-1], w_lane_sel};
        w_rnd      = '0;
        if (r_shift != 5'd0) begin
            w_rnd = (ACC_WIDTH+1)'(1) << (r_shift - 5'd1);
        end
        w_v = (w_x + w_rnd) >>> r_shift;
        if (w_v > Q_MAX) begin
            w_q = 8'h7F;
        end else if (w_v < Q_MIN) begin
            w_q = 8'h80;
        end else begin
            w_q = w_v[7:0];
        end
`ifdef OUT_RELU_EN
        if (w_q[7]) begin
            w_q = 8'h00;
        end
`endif
        w_pack_new = r_pack;
        w_pack_new[{r_byte_cnt, 3'b000} +: 8] = w_q;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ser_step  = 1'b0;
        w_push      = 1'b0;
        w_push_data = r_pack;
        w_flush_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SERIALIZE;
                end else if (r_flush_pending) begin
                    if (r_byte_cnt == '0) begin
                        w_flush_clr = 1'b1;
                    end else if (!w_full) begin
                        w_push      = 1'b1;
                        w_flush_clr = 1'b1;
                    end
                end
            end
            ST_SERIALIZE: begin
                if (!((r_byte_cnt == LAST_BYTE) && w_full)) begin
                    w_ser_step  = 1'b1;
                    w_push_data = w_pack_new;
                    if (r_byte_cnt == LAST_BYTE) begin
                        w_push = 1'b1;
                    end
                    if (r_lane_idx == r_eff_lanes - 3'd1) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_clear) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_clear_d       <= 1'b0;
            r_flush_d       <= 1'b0;
            r_flush_pending <= 1'b0;
            r_byte_cnt      <= '0;
            r_pack          <= '0;
            r_lane_idx      <= '0;
            r_eff_lanes     <= 3'd1;
            r_shift         <= '0;
            r_word_count    <= '0;
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_count         <= '0;
        end else begin
            r_clear_d <= CLEAR_FIFO;
            r_flush_d <= FLUSH;
            if (w_clear) begin
                r_flush_pending <= 1'b0;
                r_byte_cnt      <= '0;
                r_pack          <= '0;
                r_lane_idx      <= '0;
                r_word_count    <= '0;
                r_wptr          <= '0;
                r_rptr          <= '0;
                r_count         <= '0;
            end else begin
                if (w_flush_edge) begin
                    r_flush_pending <= 1'b1;
                end else if (w_flush_clr) begin
                    r_flush_pending <= 1'b0;
                end
                if (w_accept) begin
                    r_lane_idx  <= '0;
                    r_eff_lanes <= w_eff_lanes;
                    r_shift     <= PARAM_SHIFT;
                end else if (w_ser_step) begin
                    r_lane_idx  <= r_lane_idx + 3'd1;
                end
                // Clearing the pack register on every push keeps a flushed partial word zero-padded.
                if (w_push) begin
                    r_pack       <= '0;
                    r_byte_cnt   <= '0;
                    r_word_count <= r_word_count + 16'd1;
                    r_wptr       <= (r_wptr == LAST_PTR) ? '0 : r_wptr + PW'(1);
                end else if (w_ser_step) begin
                    r_pack     <= w_pack_new;
                    r_byte_cnt <= r_byte_cnt + BW'(1);
                end
                if (w_pop) begin
                    r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + PW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_lane[0] <= RES_DATA_0;
            r_lane[1] <= RES_DATA_1;
            r_lane[2] <= RES_DATA_2;
            r_lane[3] <= RES_DATA_3;
            r_lane[4] <= RES_DATA_4;
        end
        if (w_push) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

endmodule

// File: tb/tb_ofmap_out_ctrl.sv
// Directed self-checking bench for ofmap_out_ctrl with hand-computed packed words.
module tb_ofmap_out_ctrl;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic        CLEAR_FIFO;
    logic        FLUSH;
    logic [4:0]  PARAM_SHIFT;
    logic [2:0]  PARAM_LANES;
    logic        RES_VALID;
    logic        RES_READY;
    logic [31:0] RES_DATA_0, RES_DATA_1, RES_DATA_2, RES_DATA_3, RES_DATA_4;
    logic        FIFO_RD_CMD;
    logic [31:0] FIFO_RD_DATA;
    logic        FIFO_EMPTY;
    logic        FIFO_FULL;
    logic        PACK_BUSY;
    logic [15:0] WORD_COUNT;

    int n_checks = 0;
    int n_fail   = 0;

    ofmap_out_ctrl dut (
        .CLK(CLK), .RESETN(RESETN), .CLEAR_FIFO(CLEAR_FIFO), .FLUSH(FLUSH),
        .PARAM_SHIFT(PARAM_SHIFT), .PARAM_LANES(PARAM_LANES),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY),
        .RES_DATA_0(RES_DATA_0), .RES_DATA_1(RES_DATA_1), .RES_DATA_2(RES_DATA_2),
        .RES_DATA_3(RES_DATA_3), .RES_DATA_4(RES_DATA_4),
        .FIFO_RD_CMD(FIFO_RD_CMD), .FIFO_RD_DATA(FIFO_RD_DATA),
        .FIFO_EMPTY(FIFO_EMPTY), .FIFO_FULL(FIFO_FULL),
        .PACK_BUSY(PACK_BUSY), .WORD_COUNT(WORD_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!RES_READY && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check(tag, {31'd0, RES_READY}, 32'd1);
    endtask

    task automatic send_vec(input logic [4:0] sh, input logic [2:0] ln,
                            input int d0, input int d1, input int d2, input int d3, input int d4);
        PARAM_SHIFT = sh;
        PARAM_LANES = ln;
        wait_ready("ready_timeout");
        RES_DATA_0 = d0; RES_DATA_1 = d1; RES_DATA_2 = d2; RES_DATA_3 = d3; RES_DATA_4 = d4;
        RES_VALID = 1'b1;
        tick();
        RES_VALID = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp);
        check({tag, "_nonempty"}, {31'd0, FIFO_EMPTY}, 32'd0);
        check(tag, FIFO_RD_DATA, exp);
        FIFO_RD_CMD = 1'b1;
        tick();
        FIFO_RD_CMD = 1'b0;
    endtask

    task automatic pulse_clear();
        CLEAR_FIFO = 1'b1;
        tick();
        CLEAR_FIFO = 1'b0;
        tick();
    endtask

    task automatic pulse_flush();
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        logic [31:0] exp_w;
        RESETN = 1'b0; CLEAR_FIFO = 1'b0; FLUSH = 1'b0; PARAM_SHIFT = '0; PARAM_LANES = 3'd4;
        RES_VALID = 1'b0; FIFO_RD_CMD = 1'b0;
        RES_DATA_0 = '0; RES_DATA_1 = '0; RES_DATA_2 = '0; RES_DATA_3 = '0; RES_DATA_4 = '0;
        tick(); tick(); tick();
        check("rst_ready", {31'd0, RES_READY}, 32'd0);
        check("rst_empty", {31'd0, FIFO_EMPTY}, 32'd1);
        check("rst_full",  {31'd0, FIFO_FULL}, 32'd0);
        check("rst_rdata", FIFO_RD_DATA, 32'd0);
        check("rst_busy",  {31'd0, PACK_BUSY}, 32'd0);
        check("rst_wcnt",  {16'd0, WORD_COUNT}, 32'd0);
        RESETN = 1'b1;
        tick();
        check("post_rst_ready", {31'd0, RES_READY}, 32'd1);

        // 1: plain packing and ready-low duration
        send_vec(5'd0, 3'd4, 1, 2, 3, 4, 0);
        n = 0;
        while (!RES_READY && n < 20) begin
            tick();
            n++;
        end
        check("t1_ready_low", n, 32'd4);
        check("t1_wcnt", {16'd0, WORD_COUNT}, 32'd1);
        pop_check("t1_word", 32'h04030201);
        check("t1_empty", {31'd0, FIFO_EMPTY}, 32'd1);

        // 2: saturation and round-half-up
        send_vec(5'd4, 3'd4, 32767, -32767, 24, 23, 0);
        wait_ready("t2_wait");
        pop_check("t2_word", 32'h0102807F);

        // 3: five lanes leave a partial word; flush emits it zero-padded
        pulse_clear();
        send_vec(5'd0, 3'd5, 1, 2, 3, 4, 5);
        wait_ready("t3_wait");
        check("t3_busy", {31'd0, PACK_BUSY}, 32'd1);
        check("t3_wcnt1", {16'd0, WORD_COUNT}, 32'd1);
        pop_check("t3_word1", 32'h04030201);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        check("t3_ready_blocked", {31'd0, RES_READY}, 32'd0);
        tick();
        check("t3_wcnt2", {16'd0, WORD_COUNT}, 32'd2);
        check("t3_busy_after", {31'd0, PACK_BUSY}, 32'd0);
        pop_check("t3_word2", 32'h00000005);

        // 4: fill FIFO, 17th word stalls, then drain in order
        pulse_clear();
        for (int i = 0; i < 17; i++) begin
            send_vec(5'd0, 3'd4, 4*i+1, 4*i+2, 4*i+3, 4*i+4, 0);
        end
        for (int i = 0; i < 6; i++) tick();
        check("t4_full", {31'd0, FIFO_FULL}, 32'd1);
        check("t4_ready", {31'd0, RES_READY}, 32'd0);
        check("t4_wcnt16", {16'd0, WORD_COUNT}, 32'd16);
        for (int i = 0; i < 17; i++) begin
            exp_w = {8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)};
            pop_check("t4_order", exp_w);
        end
        check("t4_empty", {31'd0, FIFO_EMPTY}, 32'd1);
        check("t4_wcnt17", {16'd0, WORD_COUNT}, 32'd17);

        // 5: clear mid-serialize with a simultaneous valid
        pulse_clear();
        send_vec(5'd0, 3'd4, 1, 2, 3, 4, 0);
        wait_ready("t5_wait");
        send_vec(5'd0, 3'd4, 9, 9, 9, 9, 0);
        tick();
        CLEAR_FIFO = 1'b1;
        RES_VALID  = 1'b1;
        tick();
        RES_VALID = 1'b0;
        check("t5_empty", {31'd0, FIFO_EMPTY}, 32'd1);
        check("t5_wcnt", {16'd0, WORD_COUNT}, 32'd0);
        check("t5_ready", {31'd0, RES_READY}, 32'd1);
        check("t5_busy", {31'd0, PACK_BUSY}, 32'd0);
        CLEAR_FIFO = 1'b0;
        pulse_flush();
        tick();
        check("t5_flush_empty", {31'd0, FIFO_EMPTY}, 32'd1);
        check("t5_flush_wcnt", {16'd0, WORD_COUNT}, 32'd0);

        // clear edge in IDLE blocks a simultaneous valid
        CLEAR_FIFO = 1'b1;
        RES_VALID  = 1'b1;
        #1;
        check("t5b_ready_clear", {31'd0, RES_READY}, 32'd0);
        tick();
        RES_VALID  = 1'b0;
        CLEAR_FIFO = 1'b0;
        tick();
        check("t5b_busy", {31'd0, PACK_BUSY}, 32'd0);
        check("t5b_empty", {31'd0, FIFO_EMPTY}, 32'd1);

        // 6: negative byte, with and without ReLU
        send_vec(5'd0, 3'd4, -5, -1, 300, -300, 0);
        wait_ready("t6_wait");
`ifdef OUT_RELU_EN
        pop_check("t6_word", 32'h007F0000);
`else
        pop_check("t6_word", 32'h807FFFFB);
`endif

        // 7: shift of one, rounding toward +inf at half
        send_vec(5'd1, 3'd4, -3, 3, 5, -1, 0);
        wait_ready("t7_wait");
`ifdef OUT_RELU_EN
        pop_check("t7_word", 32'h00030200);
`else
        pop_check("t7_word", 32'h000302FF);
`endif

        // 8: lane-count clamping, LANES=0 -> 1 and LANES=7 -> 5
        pulse_clear();
        send_vec(5'd0, 3'd0, 9, 77, 77, 77, 77);
        n = 0;
        while (!RES_READY && n < 20) begin
            tick();
            n++;
        end
        check("t8_ready_low", n, 32'd1);
        check("t8_busy", {31'd0, PACK_BUSY}, 32'd1);
        send_vec(5'd0, 3'd7, 1, 2, 3, 4, 5);
        wait_ready("t8_wait");
        pop_check("t8_word1", 32'h03020109);
        pulse_flush();
        pop_check("t8_word2", 32'h00000504);
        check("t8_wcnt", {16'd0, WORD_COUNT}, 32'd2);

        // 9: reset mid-operation
        send_vec(5'd0, 3'd4, 1, 2, 3, 4, 0);
        wait_ready("t9_wait");
        send_vec(5'd0, 3'd4, 5, 6, 7, 8, 0);
        tick();
        RESETN = 1'b0;
        #1;
        check("t9_ready_rst", {31'd0, RES_READY}, 32'd0);
        tick();
        check("t9_empty", {31'd0, FIFO_EMPTY}, 32'd1);
        check("t9_wcnt", {16'd0, WORD_COUNT}, 32'd0);
        check("t9_busy", {31'd0, PACK_BUSY}, 32'd0);
        check("t9_rdata", FIFO_RD_DATA, 32'd0);
        RESETN = 1'b1;
        tick();
        check("t9_ready", {31'd0, RES_READY}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
